enc_stream_arbiter: RTL
=======================

ENC_STREAM_ARBITER -- requirements
Module: enc_stream_arbiter

Interface
REQ-001 Parameter: PKT_LEN, default 256, beats per output packet (tlast spacing), legal range 1..65535.
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: enable  input  1  1 = accept encoder events; 0 = ignore inputs while the stored events drain.
REQ-005 Port: clr_status  input  1  single-cycle pulse that clears ovf and drop_cnt.
REQ-006 Port: s_axis_tdata  input  4x64 (256, channel i at [64i+63:64i])  timestamp per channel.
REQ-007 Port: s_axis_tuser  input  4  encoder state per channel.
REQ-008 Port: s_axis_tvalid  input  4  event strobe per channel, may be a single-cycle pulse.
REQ-009 Port: s_axis_tready  output  4  tied 1; sources do not honour backpressure.
REQ-010 Port: m_axis_tdata  output  64  timestamp of granted event.
REQ-011 Port: m_axis_tuser  output  3  {channel[1:0], state}.
REQ-012 Port: m_axis_tvalid / m_axis_tready / m_axis_tlast  output/input/output  1 each  AXI-Stream master handshake.
REQ-013 Port: ovf  output  4  sticky per-channel overflow flags.
REQ-014 Port: drop_cnt  output  16  total dropped events, saturating.

Function
REQ-015 Per-channel hold register (valid, 64b data, 1b state) SHALL load on the clk edge where s_axis_tvalid[i]=1 and enable=1, provided the hold is empty or is being granted that same cycle.
REQ-016 If s_axis_tvalid[i]=1, enable=1, hold full and not granted that cycle: event dropped, hold keeps old contents, ovf[i] set, drop_cnt +1 (saturate at 0xFFFF).
REQ-017 Simultaneous grant and new capture on one channel: granted data goes to output, new event occupies the hold; no drop.
REQ-018 Output register SHALL load when empty (m_axis_tvalid=0) or when draining (m_axis_tvalid & m_axis_tready); otherwise all m_axis_* held stable.
REQ-019 Arbitration: round-robin over channels with valid hold, search starting at last_grant+1 mod 4; last_grant updates only on a grant; after reset last_grant=3 (channel 0 first).
REQ-020 Granting clears that channel's hold valid on the same edge the output register loads.
REQ-021 Latency: s_axis_tvalid in cycle N with idle output and no competitors -> m_axis_tvalid=1 in cycle N+2.
REQ-022 Full throughput: one beat per clk when m_axis_tready=1 and holds are refilled.
REQ-023 Beat counter (16b) increments on each output handshake; m_axis_tlast=1 on the beat where count==PKT_LEN-1; counter wraps to 0 after that beat; PKT_LEN=1 -> tlast on every beat.
REQ-024 tlast SHALL be computed when the beat is loaded into the output register and held stable under backpressure.
REQ-025 enable=0: no new captures, no ovf/drop updates; held events and output beat still drain normally.
REQ-026 clr_status=1 clears ovf and drop_cnt; a drop in the same cycle wins (ovf[i]=1, drop_cnt=1).

Reset
REQ-027 aresetn=0 SHALL asynchronously clear: all hold valids, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, beat counter=0, last_grant=3, ovf=0, drop_cnt=0.
REQ-028 Reset mid-packet discards held and in-flight events; first beat after release starts a new packet (count 0).
REQ-029 Outputs SHALL not assert m_axis_tvalid before the first clk edge after aresetn deasserts.

Verification
REQ-030 Single event: ch2 pulse tdata=0x1234, tuser=1, tready=1 -> two cycles later one beat tdata=0x1234, tuser=3'b101, tlast=0.
REQ-031 Fairness: all 4 channels pulse in the same cycle, tready=1 -> beats in order ch0,ch1,ch2,ch3, no drops.
REQ-032 Overflow: tready=0, ch1 pulses 3 times -> output holds first event, hold holds second, third dropped; ovf=4'b0010, drop_cnt=1; clr_status -> both 0.
REQ-033 Packetisation: PKT_LEN=4, 10 events on ch0 -> tlast on beats 4 and 8 only, beat counter=2 at end.
REQ-034 Backpressure stability: toggle tready randomly with continuous events -> m_axis_tdata/tuser/tlast constant while tvalid=1 and tready=0, no beat lost or duplicated beyond counted drops.
REQ-035 Reset mid-operation: assert aresetn=0 with output and holds full -> tvalid=0 immediately, ovf=0, drop_cnt=0; next event after release arrives as packet beat 0.

Source files
------------

// File: rtl/enc_stream_arbiter.sv
// rtl/enc_stream_arbiter.sv - four-channel encoder event capture, round-robin arbiter and AXI-Stream packetiser
module enc_stream_arbiter #(
  parameter int unsigned PKT_LEN = 256
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         enable,
  input  logic         clr_status,
  input  logic [255:0] s_axis_tdata,
  input  logic [3:0]   s_axis_tuser,
  input  logic [3:0]   s_axis_tvalid,
  output logic [3:0]   s_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic [2:0]   m_axis_tuser,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [3:0]   ovf,
  output logic [15:0]  drop_cnt
);

  localparam logic [15:0] LAST_CNT = 16'(PKT_LEN - 1);

  logic [3:0]  r_hold_vld;
  logic [63:0] r_hold_data [4];
  logic [3:0]  r_hold_state;
  logic [1:0]  r_last_grant;
  logic [63:0] r_m_tdata;
  logic [2:0]  r_m_tuser;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic [15:0] r_beat_cnt;
  logic [3:0]  r_ovf;
  logic [15:0] r_drop_cnt;

  logic        w_hs;
  logic        w_out_load;
  logic        w_grant_vld;
  logic [1:0]  w_grant_ch;
  logic        w_grant_fire;
  logic [3:0]  w_grant_oh;
  logic [3:0]  w_cap;
  logic [3:0]  w_hold_load;
  logic [3:0]  w_drop;
  logic [15:0] w_cnt_after;
  logic [2:0]  w_drop_num;
  logic [15:0] w_drop_base;
  logic [16:0] w_drop_sum;

  assign s_axis_tready = 4'hF;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign ovf           = r_ovf;
  assign drop_cnt      = r_drop_cnt;

  assign w_hs       = r_m_tvalid & m_axis_tready;
  assign w_out_load = ~r_m_tvalid | m_axis_tready;

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    logic [1:0] v_idx;
    w_grant_vld = 1'b0;
    w_grant_ch  = 2'd0;
    v_idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_last_grant + 2'(k);
      if (!w_grant_vld && r_hold_vld[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = v_idx;
      end
    end
  end

  assign w_grant_fire = w_grant_vld & w_out_load;
  assign w_grant_oh   = w_grant_fire ? (4'b0001 << w_grant_ch) : 4'b0000;

  assign w_cap       = s_axis_tvalid & {4{enable}};
  assign w_hold_load = w_cap & (~r_hold_vld | w_grant_oh);
  assign w_drop      = w_cap & r_hold_vld & ~w_grant_oh;

  // Packet index of the beat being loaded, accounting for a handshake on this same edge.
  assign w_cnt_after = w_hs ? ((r_beat_cnt == LAST_CNT) ? 16'd0 : r_beat_cnt + 16'd1)
                            : r_beat_cnt;

  assign w_drop_num  = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
  assign w_drop_base = clr_status ? 16'd0 : r_drop_cnt;
  assign w_drop_sum  = {1'b0, w_drop_base} + 17'(w_drop_num);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_hold_vld   <= 4'b0000;
      r_hold_state <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_hold_data[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_hold_load[i]) begin
          r_hold_vld[i]   <= 1'b1;
          r_hold_data[i]  <= s_axis_tdata[64*i +: 64];
          r_hold_state[i] <= s_axis_tuser[i];
        end else if (w_grant_oh[i]) begin
          r_hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= 64'd0;
      r_m_tuser    <= 3'd0;
      r_m_tlast    <= 1'b0;
      r_last_grant <= 2'd3;
    end else if (w_out_load) begin
      r_m_tvalid <= w_grant_vld;
      if (w_grant_vld) begin
        r_m_tdata    <= r_hold_data[w_grant_ch];
        r_m_tuser    <= {w_grant_ch, r_hold_state[w_grant_ch]};
        r_m_tlast    <= (w_cnt_after == LAST_CNT);
        r_last_grant <= w_grant_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt <= 16'd0;
    end else begin
      r_beat_cnt <= w_cnt_after;
    end
  end

  // A drop in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf      <= 4'b0000;
      r_drop_cnt <= 16'd0;
    end else begin
      r_ovf      <= (clr_status ? 4'b0000 : r_ovf) | w_drop;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

endmodule
